charlcd_4bit_responder: RTL and testbench

- HD44780-compatible 4-bit bus responder: the device end of the character-LCD bus that our CharLCD 4-bit peripheral drives.
- Samples RS/RW/E and assembles nibbles into bytes.
- Executes a command subset against an internal DDRAM, models the busy flag, and answers bus reads.
- Used as a synthesizable bench/loopback target for the LCD peripheral and for FPGA self-test without a panel.

---
 rtl/charlcd_pkg.sv | 39 +++
 rtl/charlcd_edge_sync.sv | 35 +++
 rtl/charlcd_4bit_responder.sv | 209 ++++++++++++++++++++
 tb/tb_charlcd_4bit_responder.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/charlcd_pkg.sv
// Shared constants and encodings for the HD44780-style 4-bit bus responder.
// Opcode mask/match pairs, fill byte, responder state and nibble phase.
package charlcd_pkg;

  localparam logic [7:0] CLEAR_MASK     = 8'hFF;
  localparam logic [7:0] CLEAR_MATCH    = 8'h01;
  localparam logic [7:0] HOME_MASK      = 8'hFE;
  localparam logic [7:0] HOME_MATCH     = 8'h02;
  localparam logic [7:0] ENTRY_MASK     = 8'hFC;
  localparam logic [7:0] ENTRY_MATCH    = 8'h04;
  localparam logic [7:0] DISPCTL_MASK   = 8'hF8;
  localparam logic [7:0] DISPCTL_MATCH  = 8'h08;
  localparam logic [7:0] FUNCSET_MASK   = 8'hE0;
  localparam logic [7:0] FUNCSET_MATCH  = 8'h20;
  localparam logic [7:0] SETDDRAM_MASK  = 8'h80;
  localparam logic [7:0] SETDDRAM_MATCH = 8'h80;

  localparam logic [7:0] FILL_BYTE = 8'h20;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_CLEAR_FILL
  } resp_state_t;

  typedef enum logic {
    PH_HIGH,
    PH_LOW
  } phase_t;

  function automatic logic op_is(
    input logic [7:0] b,
    input logic [7:0] mask,
    input logic [7:0] match
  );
    return (b & mask) == match;
  endfunction

endpackage

// File: rtl/charlcd_edge_sync.sv
// Multi-stage synchronizer for a data vector plus a strobe,
// with single-cycle rise/fall pulses on the synchronized strobe.
module charlcd_edge_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             strobe,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             rise,
  output logic             fall
);

  logic [WIDTH:0] stg [STAGES];
  logic           prev;

  // Shift the strobe and data together so they stay aligned.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) stg[i] <= '0;
      prev <= 1'b0;
    end else begin
      stg[0] <= {d, strobe};
      for (int i = 1; i < STAGES; i++) stg[i] <= stg[i-1];
      prev <= stg[STAGES-1][0];
    end
  end

  assign q    = stg[STAGES-1][WIDTH:1];
  assign rise = stg[STAGES-1][0] & ~prev;
  assign fall = ~stg[STAGES-1][0] & prev;

endmodule

// File: rtl/charlcd_4bit_responder.sv
// Device side of a character-LCD 4-bit bus: DDRAM, AC, busy, reads.
// CHARLCD_RESPONDER_INIT_SEQ_EN: boot in 8-bit mode until Function Set.
module charlcd_4bit_responder
  import charlcd_pkg::*;
#(
  parameter int DDRAM_DEPTH   = 80,
  parameter int CMD_CYCLES    = 100,
  parameter int CLEAR_CYCLES  = 200,
  parameter bit RS_INST_LEVEL = 1'b0,
  parameter int SYNC_STAGES   = 2
) (
  input  logic       mem_clk,
  input  logic       cpu_reset,
  input  logic       lcd_bus_data_select,
  input  logic       lcd_bus_read_write,
  input  logic       lcd_bus_async_enable,
  input  logic [3:0] lcd_bus_data_i,
  output logic [3:0] lcd_bus_data_o,
  output logic       lcd_bus_data_oe,
  output logic       busy_o,
  output logic [6:0] addr_counter_o,
  output logic [2:0] display_ctrl_o,
  output logic       overrun_o,
  input  logic [6:0] dbg_addr_i,
  output logic [7:0] dbg_data_o
);

`ifdef CHARLCD_RESPONDER_INIT_SEQ_EN
  localparam bit BOOT_8BIT = 1'b1;
`else
  localparam bit BOOT_8BIT = 1'b0;
`endif

  localparam int AW = $clog2(DDRAM_DEPTH);
  localparam int CLEAR_LEN =
    (DDRAM_DEPTH > CLEAR_CYCLES) ? DDRAM_DEPTH : CLEAR_CYCLES;
  localparam logic [15:0]   CMD_LEN16   = 16'(CMD_CYCLES);
  localparam logic [15:0]   CLEAR_LEN16 = 16'(CLEAR_LEN);
  localparam logic [7:0]    DEPTH8      = 8'(DDRAM_DEPTH);
  localparam logic [6:0]    AC_LAST     = 7'(DDRAM_DEPTH - 1);
  localparam logic [AW-1:0] FILL_LAST   = AW'(DDRAM_DEPTH - 1);

  logic [7:0] mem [DDRAM_DEPTH];

  logic [5:0]    sq;
  logic          e_rise, e_fall;
  logic          rs, rw;
  logic [3:0]    nib;
  phase_t        phase;
  logic [3:0]    hi;
  logic          lat_rs, lat_rw;
  logic          id, mode8, oe_q;
  logic [6:0]    ac, ac_step;
  logic [15:0]   cnt;
  logic [AW-1:0] fill;
  logic [3:0]    dout;
  logic [2:0]    disp;
  logic          ovr;
  logic [7:0]    dbg;
  resp_state_t   state, state_n;

  logic       busy, eff_low, is_inst, byte_done, accept;
  logic       clear_go, inst_go, data_we, rd_step, fill_we;
  logic [7:0] wbyte, rd_byte;

  charlcd_edge_sync #(
    .WIDTH  (6),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk    (mem_clk),
    .rst    (cpu_reset),
    .strobe (lcd_bus_async_enable),
    .d      ({lcd_bus_data_i, lcd_bus_read_write, lcd_bus_data_select}),
    .q      (sq),
    .rise   (e_rise),
    .fall   (e_fall)
  );

  assign rs   = sq[0];
  assign rw   = sq[1];
  assign nib  = sq[5:2];
  assign busy = |cnt;

  // Byte assembly, command classification and AC stepping.
  always_comb begin
    eff_low   = !mode8 && (phase == PH_LOW)
                && (rs == lat_rs) && (rw == lat_rw);
    is_inst   = (rs == RS_INST_LEVEL);
    wbyte     = mode8 ? {nib, 4'h0} : {hi, nib};
    byte_done = e_fall && !rw && (mode8 || eff_low);
    accept    = byte_done && !busy;
    clear_go  = accept && is_inst
                && op_is(wbyte, CLEAR_MASK, CLEAR_MATCH);
    inst_go   = accept && is_inst;
    data_we   = accept && !is_inst;
    rd_step   = e_fall && rw && !is_inst && (mode8 || eff_low);
    rd_byte   = is_inst ? {busy, ac} : mem[ac[AW-1:0]];
    if (id) ac_step = (ac == AC_LAST) ? 7'd0 : ac + 7'd1;
    else    ac_step = (ac == 7'd0) ? AC_LAST : ac - 7'd1;
  end

  // Responder state register.
  always_ff @(posedge mem_clk) begin
    if (cpu_reset) state <= ST_IDLE;
    else           state <= state_n;
  end

  // Next state: clear walks DDRAM, then waits out the busy count.
  always_comb begin
    state_n = state;
    fill_we = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (clear_go)    state_n = ST_CLEAR_FILL;
        else if (accept) state_n = ST_EXEC;
      end
      ST_EXEC: begin
        if (cnt <= 16'd1) state_n = ST_IDLE;
      end
      ST_CLEAR_FILL: begin
        fill_we = 1'b1;
        if (fill == FILL_LAST) state_n = ST_EXEC;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // DDRAM is not reset; reset only suppresses an in-flight fill.
  always_ff @(posedge mem_clk) begin
    if (!cpu_reset) begin
      if (fill_we)      mem[fill] <= FILL_BYTE;
      else if (data_we) mem[ac[AW-1:0]] <= wbyte;
    end
  end

  // Bus phase, read drive, instruction execution and busy timing.
  always_ff @(posedge mem_clk) begin
    if (cpu_reset) begin
      phase  <= PH_HIGH;
      hi     <= 4'h0;
      lat_rs <= 1'b0;
      lat_rw <= 1'b0;
      id     <= 1'b1;
      mode8  <= BOOT_8BIT;
      oe_q   <= 1'b0;
      dout   <= 4'h0;
      ac     <= 7'd0;
      cnt    <= 16'd0;
      fill   <= '0;
      disp   <= 3'b000;
      ovr    <= 1'b0;
      dbg    <= 8'h00;
    end else begin
      if (!rw) oe_q <= 1'b0;
      if (e_rise && rw) begin
        oe_q <= 1'b1;
        dout <= eff_low ? rd_byte[3:0] : rd_byte[7:4];
      end
      if (e_fall) begin
        oe_q <= 1'b0;
        if (mode8 || eff_low) begin
          phase <= PH_HIGH;
        end else begin
          hi     <= nib;
          lat_rs <= rs;
          lat_rw <= rw;
          phase  <= PH_LOW;
        end
      end
      if (byte_done && busy) ovr <= 1'b1;
      if (clear_go) begin
        ac <= 7'd0;
        id <= 1'b1;
      end else if (inst_go) begin
        unique case (1'b1)
          op_is(wbyte, SETDDRAM_MASK, SETDDRAM_MATCH):
            ac <= ({1'b0, wbyte[6:0]} < DEPTH8) ? wbyte[6:0] : 7'd0;
          op_is(wbyte, FUNCSET_MASK, FUNCSET_MATCH):
            if (BOOT_8BIT && !wbyte[4]) mode8 <= 1'b0;
          op_is(wbyte, DISPCTL_MASK, DISPCTL_MATCH):
            disp <= wbyte[2:0];
          op_is(wbyte, ENTRY_MASK, ENTRY_MATCH):
            id <= wbyte[1];
          op_is(wbyte, HOME_MASK, HOME_MATCH):
            ac <= 7'd0;
          default: ;
        endcase
      end else if (data_we || rd_step) begin
        ac <= ac_step;
      end
      if (clear_go)    cnt <= CLEAR_LEN16;
      else if (accept) cnt <= CMD_LEN16;
      else if (busy)   cnt <= cnt - 16'd1;
      if (clear_go)     fill <= '0;
      else if (fill_we) fill <= fill + 1'b1;
      dbg <= ({1'b0, dbg_addr_i} < DEPTH8)
             ? mem[dbg_addr_i[AW-1:0]] : 8'h00;
    end
  end

  assign lcd_bus_data_o  = dout;
  assign lcd_bus_data_oe = oe_q & rw;
  assign busy_o          = busy;
  assign addr_counter_o  = ac;
  assign display_ctrl_o  = disp;
  assign overrun_o       = ovr;
  assign dbg_data_o      = dbg;

endmodule

// File: tb/tb_charlcd_4bit_responder.sv
// Directed bench for charlcd_4bit_responder with a scoreboard queue.
// Expected values are queued at stimulus and popped when observed.
module tb_charlcd_4bit_responder;

  logic       mem_clk = 1'b0;
  logic       cpu_reset = 1'b1;
  logic       lcd_bus_data_select = 1'b0;
  logic       lcd_bus_read_write = 1'b0;
  logic       lcd_bus_async_enable = 1'b0;
  logic [3:0] lcd_bus_data_i = 4'h0;
  logic [3:0] lcd_bus_data_o;
  logic       lcd_bus_data_oe;
  logic       busy_o;
  logic [6:0] addr_counter_o;
  logic [2:0] display_ctrl_o;
  logic       overrun_o;
  logic [6:0] dbg_addr_i = 7'd0;
  logic [7:0] dbg_data_o;

  charlcd_4bit_responder dut (
    .mem_clk              (mem_clk),
    .cpu_reset            (cpu_reset),
    .lcd_bus_data_select  (lcd_bus_data_select),
    .lcd_bus_read_write   (lcd_bus_read_write),
    .lcd_bus_async_enable (lcd_bus_async_enable),
    .lcd_bus_data_i       (lcd_bus_data_i),
    .lcd_bus_data_o       (lcd_bus_data_o),
    .lcd_bus_data_oe      (lcd_bus_data_oe),
    .busy_o               (busy_o),
    .addr_counter_o       (addr_counter_o),
    .display_ctrl_o       (display_ctrl_o),
    .overrun_o            (overrun_o),
    .dbg_addr_i           (dbg_addr_i),
    .dbg_data_o           (dbg_data_o)
  );

  always #5 mem_clk = ~mem_clk;

  typedef struct {
    string       tag;
    logic [15:0] val;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;
  int   run = 0;
  int   last_run = 0;

  always @(posedge mem_clk) begin
    if (busy_o) run++;
    else if (run != 0) begin
      last_run = run;
      run = 0;
    end
  end

  task automatic expect_val(input string t, input logic [15:0] v);
    sbq.push_back('{t, v});
  endtask

  task automatic observe(input logic [15:0] obs);
    exp_t e;
    checks++;
    if (sbq.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%h", obs);
    end else begin
      e = sbq.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic put_nibble(input logic rs, input logic [3:0] n);
    @(negedge mem_clk);
    lcd_bus_data_select = rs;
    lcd_bus_read_write = 1'b0;
    lcd_bus_data_i = n;
    repeat (3) @(negedge mem_clk);
    lcd_bus_async_enable = 1'b1;
    repeat (4) @(negedge mem_clk);
    lcd_bus_async_enable = 1'b0;
    repeat (5) @(negedge mem_clk);
  endtask

  task automatic put_byte(input logic rs, input logic [7:0] b);
    put_nibble(rs, b[7:4]);
    put_nibble(rs, b[3:0]);
  endtask

  task automatic get_nibble(input logic rs, output logic [3:0] n,
                            output logic oe_on, output logic oe_off);
    @(negedge mem_clk);
    lcd_bus_data_select = rs;
    lcd_bus_read_write = 1'b1;
    repeat (3) @(negedge mem_clk);
    lcd_bus_async_enable = 1'b1;
    repeat (4) @(negedge mem_clk);
    n = lcd_bus_data_o;
    oe_on = lcd_bus_data_oe;
    lcd_bus_async_enable = 1'b0;
    repeat (5) @(negedge mem_clk);
    oe_off = lcd_bus_data_oe;
    lcd_bus_read_write = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy_o && n < 1000) begin
      @(negedge mem_clk);
      n++;
    end
    checks++;
    assert (!busy_o) else begin
      errors++;
      $error("FAIL busy_timeout observed=%0b expected=0", busy_o);
    end
    repeat (2) @(negedge mem_clk);
  endtask

  task automatic dbg_read(input logic [6:0] a, output logic [7:0] v);
    @(negedge mem_clk);
    dbg_addr_i = a;
    repeat (2) @(negedge mem_clk);
    v = dbg_data_o;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v;
    logic [3:0] n;
    logic       oe_on, oe_off;

    repeat (4) @(negedge mem_clk);
    expect_val("rst_data_o", 16'h0);  observe(16'(lcd_bus_data_o));
    expect_val("rst_oe", 16'h0);      observe(16'(lcd_bus_data_oe));
    expect_val("rst_busy", 16'h0);    observe(16'(busy_o));
    expect_val("rst_ac", 16'h0);      observe(16'(addr_counter_o));
    expect_val("rst_disp", 16'h0);    observe(16'(display_ctrl_o));
    expect_val("rst_ovr", 16'h0);     observe(16'(overrun_o));
    expect_val("rst_dbg", 16'h0);     observe(16'(dbg_data_o));
    cpu_reset = 1'b0;
    repeat (2) @(negedge mem_clk);

`ifdef CHARLCD_RESPONDER_INIT_SEQ_EN
    put_nibble(1'b0, 4'h2);
    wait_idle();
    put_byte(1'b0, 8'h28);
    wait_idle();
`endif

    last_run = 0;
    put_byte(1'b1, 8'h41);
    wait_idle();
    expect_val("w41_busy_len", 16'd100); observe(16'(last_run));
    dbg_read(7'd0, v);
    expect_val("w41_ddram0", 16'h41);    observe(16'(v));
    expect_val("w41_ac", 16'h1);         observe(16'(addr_counter_o));
    expect_val("w41_ovr", 16'h0);        observe(16'(overrun_o));

    put_byte(1'b0, 8'hC5);
    wait_idle();
    expect_val("setddram_45", 16'h45);   observe(16'(addr_counter_o));
    put_byte(1'b0, 8'hD5);
    wait_idle();
    expect_val("setddram_oob", 16'h0);   observe(16'(addr_counter_o));

    for (int i = 0; i < 80; i++) begin
      put_byte(1'b1, 8'h55);
      wait_idle();
    end
    expect_val("fill_wrap_ac", 16'h0);   observe(16'(addr_counter_o));
    dbg_read(7'd79, v);
    expect_val("fill_ddram79", 16'h55);  observe(16'(v));

    last_run = 0;
    put_byte(1'b0, 8'h01);
    get_nibble(1'b0, n, oe_on, oe_off);
    expect_val("clr_rd_hi", 16'h8);      observe(16'(n));
    expect_val("clr_rd_oe_on", 16'h1);   observe(16'(oe_on));
    expect_val("clr_rd_oe_off", 16'h0);  observe(16'(oe_off));
    get_nibble(1'b0, n, oe_on, oe_off);
    expect_val("clr_rd_lo", 16'h0);      observe(16'(n));
    put_byte(1'b1, 8'h42);
    expect_val("clr_overrun", 16'h1);    observe(16'(overrun_o));
    expect_val("clr_busy_mid", 16'h1);   observe(16'(busy_o));
    wait_idle();
    expect_val("clr_busy_ge200", 16'h1); observe(16'(last_run >= 200));
    expect_val("clr_ac", 16'h0);         observe(16'(addr_counter_o));
    for (int i = 0; i < 80; i++) begin
      dbg_read(7'(i), v);
      expect_val($sformatf("clr_ddram%0d", i), 16'h20);
      observe(16'(v));
    end

    put_byte(1'b0, 8'hCF);
    wait_idle();
    put_byte(1'b1, 8'h5A);
    wait_idle();
    dbg_read(7'd79, v);
    expect_val("wrap_ddram79", 16'h5A);  observe(16'(v));
    expect_val("wrap_inc_ac", 16'h0);    observe(16'(addr_counter_o));
    put_byte(1'b0, 8'h04);
    wait_idle();
    put_byte(1'b1, 8'h5B);
    wait_idle();
    dbg_read(7'd0, v);
    expect_val("wrap_ddram0", 16'h5B);   observe(16'(v));
    expect_val("wrap_dec_ac", 16'd79);   observe(16'(addr_counter_o));

    put_byte(1'b0, 8'h8A);
    wait_idle();
    put_nibble(1'b1, 4'h6);
    put_nibble(1'b0, 4'h0);
    put_nibble(1'b0, 4'hC);
    wait_idle();
    expect_val("mis_disp", 16'h4);       observe(16'(display_ctrl_o));
    expect_val("mis_ac", 16'd10);        observe(16'(addr_counter_o));
    dbg_read(7'd10, v);
    expect_val("mis_ddram10", 16'h20);   observe(16'(v));

    get_nibble(1'b1, n, oe_on, oe_off);
    expect_val("drd_hi", 16'h2);         observe(16'(n));
    get_nibble(1'b1, n, oe_on, oe_off);
    expect_val("drd_lo", 16'h0);         observe(16'(n));
    expect_val("drd_ac_dec", 16'd9);     observe(16'(addr_counter_o));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
